// File: rtl/arb_wrr_pkt_pkg.sv
// Shared types and helpers for the weighted round-robin packet arbiter.
package arb_wrr_pkg;

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    HOLD = 2'd1,
    REL  = 2'd2
  } state_e;

  localparam int N_DEF  = 4;
  localparam int WW_DEF = 4;
  localparam int IDW    = $clog2(N_DEF);

  // Callers guarantee at most one bit set; all-zero maps to index 0.
  function automatic int unsigned onehot2bin(input logic [31:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (oh[i]) idx |= i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_wrr_pkt_if.sv
// Requester/resource side signals of the arbiter, grouped as one bundle.
interface arb_wrr_pkt_if
  import arb_wrr_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int WW = WW_DEF
);
  localparam int IW = $clog2(N);

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_last;
  logic [N*WW-1:0] weight;
  logic            res_ready;
  logic [N-1:0]    grant;
  logic [IW-1:0]   grant_id;
  logic            beat_fire;
  logic [WW-1:0]   credit_left;

  modport master (
    output req_valid, req_last, weight, res_ready,
    input  grant, grant_id, beat_fire, credit_left
  );

  modport slave (
    input  req_valid, req_last, weight, res_ready,
    output grant, grant_id, beat_fire, credit_left
  );

endinterface

// File: rtl/arb_wrr_pkt_rr_pick.sv
// Rotating-priority picker: first set bit of req strictly after ptr, wrapping.
module arb_rr_pick
  import arb_wrr_pkg::*;
#(
  parameter  int N  = N_DEF,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          any,
  output logic [IW-1:0] pick_id
);

  logic [2*N-1:0] mask;
  logic [2*N-1:0] cand;

  // Window ptr+1 .. ptr+N over the doubled vector covers every index once.
  generate
    for (genvar gi = 0; gi < 2*N; gi++) begin : g_mask
      assign mask[gi] = (gi > int'(ptr)) && (gi <= int'(ptr) + N);
    end
  endgenerate

  assign cand = {req, req} & mask;
  assign any  = |cand;

  always_comb begin
    pick_id = '0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (cand[j]) pick_id = IW'(j % N);
    end
  end

endmodule

// File: rtl/arb_wrr_pkt.sv
// Weighted round-robin packet arbiter: whole-packet grants, up to weight
// packets per grant, one idle bubble between grants.
module arb_wrr_pkt
  import arb_wrr_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int WW = WW_DEF
) (
  input  logic         clock,
  input  logic         reset,
  arb_wrr_pkt_if.slave bus
);
  localparam int IW = $clog2(N);

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [WW-1:0] credit_q, credit_d;
  logic          in_pkt_q, in_pkt_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic          pick_any;
  logic [IW-1:0] pick_id;
  logic [IW-1:0] cur_id;
  logic [WW-1:0] pick_w;

  arb_rr_pick #(.N(N)) u_pick (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .any     (pick_any),
    .pick_id (pick_id)
  );

  assign cur_id          = IW'(onehot2bin(32'(grant_q)));
  assign pick_w          = bus.weight[pick_id*WW +: WW];
  assign bus.grant       = grant_q;
  assign bus.grant_id    = cur_id;
  assign bus.credit_left = credit_q;
  assign bus.beat_fire   = (|(grant_q & bus.req_valid)) & bus.res_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ARB;
      grant_q  <= '0;
      credit_q <= '0;
      in_pkt_q <= 1'b0;
      ptr_q    <= IW'(N-1);
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      credit_q <= credit_d;
      in_pkt_q <= in_pkt_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    credit_d = credit_q;
    in_pkt_d = in_pkt_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      // The REL cycle is the bubble; arbitration for the next grant runs in
      // it against the already-updated pointer, so the gap is exactly 1 cycle.
      ARB, REL: begin
        in_pkt_d = 1'b0;
        if (pick_any) begin
          state_d  = HOLD;
          grant_d  = N'(1) << pick_id;
          credit_d = (pick_w == '0) ? WW'(1) : pick_w;
        end else begin
          state_d  = ARB;
          grant_d  = '0;
          credit_d = '0;
        end
      end
      HOLD: begin
        if (bus.beat_fire) begin
          if (bus.req_last[cur_id]) begin
            credit_d = credit_q - WW'(1);
            in_pkt_d = 1'b0;
            if (credit_q == WW'(1)) begin
              state_d  = REL;
              grant_d  = '0;
              credit_d = '0;
              ptr_d    = cur_id;
            end
          end else begin
            in_pkt_d = 1'b1;
          end
        end else if (!in_pkt_q && !bus.req_valid[cur_id]) begin
          state_d  = REL;
          grant_d  = '0;
          credit_d = '0;
          ptr_d    = cur_id;
        end
      end
      default: begin
        state_d  = ARB;
        grant_d  = '0;
        credit_d = '0;
        in_pkt_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_arb_wrr_pkt.sv
// Directed checks of arb_wrr_pkt grant sequencing, credits and hold behaviour.
module tb_arb_wrr_pkt;
  import arb_wrr_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  arb_wrr_pkt_if #(.N(4), .WW(4)) bus_if ();

  arb_wrr_pkt #(.N(4), .WW(4)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s val=%0h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_in(input logic [3:0] v, input logic [3:0] l, input logic [15:0] w, input logic r);
    bus_if.req_valid = v;
    bus_if.req_last  = l;
    bus_if.weight    = w;
    bus_if.res_ready = r;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    set_in(4'b0000, 4'b0000, 16'h1111, 1'b0);
    step();
    step();
    check_eq({tag, "_rst_grant"},  32'(bus_if.grant), 32'h0);
    check_eq({tag, "_rst_id"},     32'(bus_if.grant_id), 32'h0);
    check_eq({tag, "_rst_credit"}, 32'(bus_if.credit_left), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    int g1 [9] = '{1, 0, 2, 0, 4, 0, 8, 0, 1};
    int g2 [7] = '{1, 1, 1, 0, 2, 0, 1};
    int c2 [7] = '{3, 2, 1, 0, 1, 0, 3};
    int g3 [9] = '{4, 4, 4, 4, 4, 4, 4, 0, 1};
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    set_in(4'b0000, 4'b0000, 16'h1111, 1'b0);

    // 1: plain round robin, weight 1, single-beat packets
    do_reset("t1");
    set_in(4'b1111, 4'b1111, 16'h1111, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step();
      check_eq($sformatf("t1_grant%0d", i), 32'(bus_if.grant), 32'(g1[i]));
    end

    // 2: weight 3 vs weight 1
    do_reset("t2");
    set_in(4'b0011, 4'b0011, 16'h1113, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq($sformatf("t2_grant%0d", i), 32'(bus_if.grant), 32'(g2[i]));
      check_eq($sformatf("t2_credit%0d", i), 32'(bus_if.credit_left), 32'(c2[i]));
    end

    // 3: 4-beat packet with stalls; no pre-emption
    do_reset("t3");
    set_in(4'b0100, 4'b0000, 16'h1111, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step();
      check_eq($sformatf("t3_grant%0d", i), 32'(bus_if.grant), 32'(g3[i]));
      case (i)
        1: begin bus_if.res_ready = 1'b0; bus_if.req_valid = 4'b0101; end
        2: begin
          bus_if.res_ready = 1'b1; bus_if.req_valid = 4'b0001;
          #1 check_eq("t3_nofire", 32'(bus_if.beat_fire), 32'h0);
        end
        3: begin bus_if.req_valid = 4'b0101; bus_if.res_ready = 1'b1; end
        4: bus_if.res_ready = 1'b0;
        5: bus_if.res_ready = 1'b1;
        6: begin
          bus_if.req_last = 4'b0100;
          check_eq("t3_credit", 32'(bus_if.credit_left), 32'h1);
          #1 check_eq("t3_lastfire", 32'(bus_if.beat_fire), 32'h1);
        end
        default: ;
      endcase
    end
    check_eq("t3_id", 32'(bus_if.grant_id), 32'h0);

    // 4: early release of unused credit
    do_reset("t4");
    set_in(4'b0110, 4'b0110, 16'h1151, 1'b1);
    step();
    check_eq("t4_grant", 32'(bus_if.grant), 32'h2);
    check_eq("t4_credit5", 32'(bus_if.credit_left), 32'h5);
    step();
    check_eq("t4_credit4", 32'(bus_if.credit_left), 32'h4);
    step();
    check_eq("t4_credit3", 32'(bus_if.credit_left), 32'h3);
    bus_if.req_valid = 4'b0100;
    step();
    check_eq("t4_rel_grant", 32'(bus_if.grant), 32'h0);
    check_eq("t4_rel_credit", 32'(bus_if.credit_left), 32'h0);
    step();
    check_eq("t4_next_grant", 32'(bus_if.grant), 32'h4);
    check_eq("t4_next_id", 32'(bus_if.grant_id), 32'h2);
    check_eq("t4_next_credit", 32'(bus_if.credit_left), 32'h1);

    // 5: zero weight behaves as one
    do_reset("t5");
    set_in(4'b1000, 4'b1000, 16'h0111, 1'b1);
    step();
    check_eq("t5_grant_a", 32'(bus_if.grant), 32'h8);
    check_eq("t5_id_a", 32'(bus_if.grant_id), 32'h3);
    check_eq("t5_credit_a", 32'(bus_if.credit_left), 32'h1);
    step();
    check_eq("t5_bubble", 32'(bus_if.grant), 32'h0);
    step();
    check_eq("t5_grant_b", 32'(bus_if.grant), 32'h8);
    check_eq("t5_credit_b", 32'(bus_if.credit_left), 32'h1);
    step();
    check_eq("t5_bubble_b", 32'(bus_if.grant), 32'h0);

    // 6: reset mid-packet aborts the grant
    do_reset("t6");
    set_in(4'b0010, 4'b0000, 16'h1111, 1'b1);
    step();
    check_eq("t6_grant", 32'(bus_if.grant), 32'h2);
    step();
    check_eq("t6_hold", 32'(bus_if.grant), 32'h2);
    rst = 1'b1;
    bus_if.req_valid = 4'b1111;
    step();
    check_eq("t6_abort_grant", 32'(bus_if.grant), 32'h0);
    check_eq("t6_abort_credit", 32'(bus_if.credit_left), 32'h0);
    rst = 1'b0;
    step();
    check_eq("t6_regrant", 32'(bus_if.grant), 32'h1);
    check_eq("t6_regrant_id", 32'(bus_if.grant_id), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_wrr_pkt.md
Name: arb_wrr_pkt

Overview:
- Weighted round-robin packet arbiter that shares one downstream resource (bus/FIFO write port) among N requesters.
- Grant is held for a whole packet and is never pre-empted mid-packet.
- Each requester may send up to its programmed weight in consecutive packets per grant, then priority rotates.
- Sits in front of the shared datapath and replaces lock-based handshaking with per-beat valid/ready.

Parameters:
- N, 4, number of requesters (>=2).
- WW, 4, width of each per-requester weight field (packets per grant).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N  per-requester beat valid.
- req_last  in  N  per-requester last-beat-of-packet flag, qualified by req_valid.
- weight  in  N*WW  per-requester quantum; field i is weight[i*WW +: WW]; value 0 is treated as 1.
- res_ready  in  1  shared resource accepts a beat this cycle.
- grant  out  N  registered one-hot grant; all zero when idle.
- grant_id  out  $clog2(N)  binary index of the granted requester; 0 when idle.
- beat_fire  out  1  combinational: |(grant & req_valid) & res_ready.
- credit_left  out  WW  remaining packets in the current grant, including the packet in progress.

Behaviour:
- Reset (synchronous, takes effect at the next clock edge): grant=0, grant_id=0, credit_left=0, state=ARB, rr pointer=N-1 so requester 0 has highest priority. Reset asserted mid-packet aborts the grant at that edge with no drain.
- States: ARB, HOLD, REL.
- ARB:
  - If |req_valid, pick the first valid requester starting at pointer+1 and wrapping modulo N.
  - Next edge: grant=onehot(pick), grant_id=pick, credit_left=max(weight[pick],1), state=HOLD.
  - Otherwise stay in ARB with outputs at 0.
  - Request-to-grant latency is 1 cycle.
- HOLD:
  - A transfer occurs when beat_fire=1 (g = grant_id).
  - A transfer with req_last[g]=1 ends the packet and decrements credit_left.
  - If the decremented credit_left is 0, go to REL.
  - Otherwise stay in HOLD and mark the requester as between packets (in_pkt=0).
  - A transfer with req_last[g]=0 sets in_pkt=1.
  - While in_pkt=1, a low req_valid[g] or res_ready keeps the grant (no pre-emption, wait indefinitely).
  - While in_pkt=0 and req_valid[g]=0 for one cycle, go to REL (early release of unused credit).
- REL (one cycle): grant=0, grant_id=0, credit_left=0, pointer<=g, then go to ARB. This gives a mandatory 1-cycle bubble between different grants and between back-to-back grants to the same requester.
- Weight is sampled only in ARB on the grant edge. Changes during HOLD have no effect until the next grant.
- Only req_valid/req_last of the granted index are observed in HOLD. Other requesters wait.
- A single requester with continuous traffic gets weight packets, then REL, then is re-granted (its own pointer position means it wraps to itself last, and wins when alone).
- Fairness bound: a continuously requesting requester waits at most sum of other weights' packets plus N bubble cycles.

Decomposition:
- Package arb_wrr_pkg holds:
  - the state enum (ARB, HOLD, REL);
  - the localparam IDW = $clog2(N) expression;
  - a function onehot2bin.
- One sub-module, arb_rr_pick: combinational rotate-priority picker.
  - Inputs: req[N], ptr[IDW].
  - Outputs: any, pick_id[IDW].
  - Implemented by double-width masked priority encoding.
  - Instantiated once in arb_wrr_pkt.

Test Plan:
1. Reset, then req_valid=4'b1111, all weights=1, 1-beat packets, res_ready=1 -> grants 0,1,2,3,0 in order, each grant 1 cycle with a 1-cycle REL bubble, first grant 1 cycle after request.
2. weight0=3, weight1=1, req_valid=4'b0011, 1-beat packets -> grant sequence 0,0,0 (credit_left 3,2,1, one HOLD) then REL, then 1, then 0; credit_left=0 in REL.
3. Requester 2 alone with a 4-beat packet, res_ready toggling 1,0,1,0 and req_valid[2] dropping mid-packet -> grant stays 4'b0100 until the 4th beat with req_last fires; no other requester granted even if req_valid[0]=1 asserts mid-packet.
4. weight1=5, requester 1 sends 2 packets then drops req_valid while in_pkt=0 -> REL the next cycle with credit_left=3 beforehand, then requester 2 is granted (pointer=1).
5. weight field=0 for requester 3 -> treated as 1: exactly one packet per grant, credit_left=1 at grant.
6. reset asserted for 1 cycle during HOLD mid-packet of requester 1 -> after that edge grant=0, credit_left=0; with all requests valid, the next grant is requester 0.
